// File: rtl/ysyx_25020037_icache_pkg.sv
// rtl/ysyx_25020037_icache_pkg.sv - shared icache configuration: defaults, FSM encoding, width derivations
package ysyx_25020037_icache_pkg;

  localparam int NUM_LINES_DEF = 16;
  localparam int ADDR_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Word-aligned lines: two byte-offset bits sit below the index.
  function automatic int tag_width(input int addr_w, input int num_lines);
    return addr_w - $clog2(num_lines) - 2;
  endfunction

endpackage

// File: rtl/ysyx_25020037_icache_array.sv
// rtl/ysyx_25020037_icache_array.sv - flop-based valid/tag/data store with async read and global invalidate
module ysyx_25020037_icache_array #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             inv
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (rst || inv) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/ysyx_25020037_icache.sv
// rtl/ysyx_25020037_icache.sv - direct-mapped single-word-line instruction cache with refill FSM and counters
module ysyx_25020037_icache
  import ysyx_25020037_icache_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              icache_req,
  output logic              icache_hit,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              icache_ready,
  output logic [31:0]       icache_data,
  input  logic              fence_i,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int IDX_W = idx_width(NUM_LINES);
  localparam int TAG_W = tag_width(ADDR_W, NUM_LINES);

  state_t           state_q, state_d;
  logic             fence_pend_q;
  logic [IDX_W-1:0] miss_index_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [31:0]      refill_data_q;

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             lookup, hit, miss, inv, wr_en;
  logic             unused_ok;

  assign index     = pc[IDX_W+1:2];
  assign tag       = pc[ADDR_W-1:IDX_W+2];
  assign unused_ok = ^pc[1:0];

  ysyx_25020037_icache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(miss_index_q),
    .wr_tag  (miss_tag_q),
    .wr_data (mem_rdata),
    .inv     (inv)
  );

  always_comb begin
    state_d      = state_q;
    // A pending or same-cycle invalidate makes every line look invalid to this lookup.
    inv          = (state_q == IDLE) && (fence_i || fence_pend_q);
    lookup       = !rst && (state_q == IDLE) && icache_req;
    hit          = lookup && !inv && rd_valid && (rd_tag == tag);
    miss         = lookup && !hit;
    wr_en        = !rst && (state_q == REFILL) && mem_ready;
    icache_hit   = hit;
    mem_req      = miss;
    icache_ready = !rst && (state_q == DONE);
    icache_data  = 32'h0;
    if (hit) begin
      icache_data = rd_data;
    end else if (icache_ready) begin
      icache_data = refill_data_q;
    end
    case (state_q)
      IDLE:    if (miss) state_d = REFILL;
      REFILL:  if (mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fence_pend_q  <= 1'b0;
      refill_data_q <= 32'h0;
      hit_cnt       <= 32'h0;
      miss_cnt      <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        fence_pend_q <= 1'b0;
      end else if (fence_i) begin
        fence_pend_q <= 1'b1;
      end
      if (wr_en) begin
        refill_data_q <= mem_rdata;
      end
      if (hit && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      miss_index_q <= index;
      miss_tag_q   <= tag;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// tb/tb_ysyx_25020037_icache.sv - directed bench with a cycle-level behavioural cache model
module tb_ysyx_25020037_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        icache_req = 1'b0;
  logic        icache_hit, mem_req, icache_ready;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] icache_data, hit_cnt, miss_cnt;
  logic        fence_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_25020037_icache dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .icache_req  (icache_req),
    .icache_hit  (icache_hit),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .icache_ready(icache_ready),
    .icache_data (icache_data),
    .fence_i     (fence_i),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  // Model: line contents by index, plus whether a refill is outstanding or just finished.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_busy = 0, m_done = 0, m_pend = 0;
  logic [31:0] m_refill_pc = 0, m_rdata = 0, m_hits = 0, m_misses = 0;

  function automatic bit m_lookup();
    return !rst && !m_busy && !m_done && icache_req;
  endfunction

  function automatic bit m_is_hit();
    int i;
    i = (pc >> 2) % 16;
    return m_lookup() && !(fence_i || m_pend) && m_valid[i] && m_tag[i] == pc[31:6];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit h, rdy;
    h   = m_is_hit();
    rdy = !rst && m_done;
    check("model_hit", {31'b0, icache_hit}, {31'b0, h});
    check("model_mem_req", {31'b0, mem_req}, {31'b0, m_lookup() && !h});
    check("model_ready", {31'b0, icache_ready}, {31'b0, rdy});
    check("model_data", icache_data, h ? m_data[(pc >> 2) % 16] : (rdy ? m_rdata : 32'h0));
    check("model_hit_cnt", hit_cnt, m_hits);
    check("model_miss_cnt", miss_cnt, m_misses);
  end

  always @(posedge clk) begin
    bit h, look;
    h    = m_is_hit();
    look = m_lookup();
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_busy = 0; m_done = 0; m_pend = 0; m_rdata = 0; m_hits = 0; m_misses = 0;
    end else if (!m_busy && !m_done) begin
      if (fence_i || m_pend) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_pend = 0;
      end
      if (look && h) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      end else if (look) begin
        if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
        m_busy = 1;
        m_refill_pc = pc;
      end
    end else if (m_busy) begin
      if (fence_i) m_pend = 1;
      if (mem_ready) begin
        m_valid[(m_refill_pc >> 2) % 16] = 1;
        m_tag[(m_refill_pc >> 2) % 16]   = m_refill_pc[31:6];
        m_data[(m_refill_pc >> 2) % 16]  = mem_rdata;
        m_rdata = mem_rdata;
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      if (fence_i) m_pend = 1;
      m_done = 0;
    end
  end

  task automatic cyc(input bit req, input logic [31:0] a, input bit f, input bit mr, input logic [31:0] rd);
    @(posedge clk);
    #1;
    icache_req = req; pc = a; fence_i = f; mem_ready = mr; mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic refill(input logic [31:0] rd);
    cyc(0, 32'h0, 0, 1, rd);
    idle();
  endtask

  initial begin
    idle();
    idle();
    check("rst_hit", {31'b0, icache_hit}, 32'h0);
    check("rst_data", icache_data, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Cold miss, refill arrives three cycles after the request.
    cyc(1, 32'h8000_0000, 0, 0, 0);
    check("cold_mem_req", {31'b0, mem_req}, 32'h1);
    idle(); idle();
    cyc(0, 32'h0, 0, 1, 32'h0000_0413);
    idle();
    check("cold_ready", {31'b0, icache_ready}, 32'h1);
    check("cold_data", icache_data, 32'h0000_0413);
    check("cold_miss_cnt", miss_cnt, 32'd1);

    cyc(1, 32'h8000_0000, 0, 0, 0);
    check("hit_flag", {31'b0, icache_hit}, 32'h1);
    check("hit_data", icache_data, 32'h0000_0413);
    check("hit_no_mem_req", {31'b0, mem_req}, 32'h0);
    idle();
    check("hit_cnt", hit_cnt, 32'd1);

    // Conflict on index 0 evicts the earlier line.
    cyc(1, 32'h8000_0040, 0, 0, 0);
    check("conflict_miss", {31'b0, mem_req}, 32'h1);
    refill(32'h1111_1111);
    cyc(1, 32'h8000_0000, 0, 0, 0);
    check("evicted_miss", {31'b0, mem_req}, 32'h1);
    refill(32'h0000_0413);

    // fence_i during refill invalidates the refilled line afterwards.
    cyc(1, 32'h8000_0004, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0);
    cyc(0, 32'h0, 0, 1, 32'h2222_2222);
    idle();
    check("fence_ready", {31'b0, icache_ready}, 32'h1);
    check("fence_ready_data", icache_data, 32'h2222_2222);
    cyc(1, 32'h8000_0004, 0, 0, 0);
    check("fence_then_miss", {31'b0, mem_req}, 32'h1);
    refill(32'h2222_2222);

    // fence_i in IDLE with a request that would otherwise hit.
    cyc(1, 32'h8000_0004, 1, 0, 0);
    check("fence_idle_miss", {31'b0, mem_req}, 32'h1);
    refill(32'h3333_3333);

    // Ignored inputs: request in DONE, mem_ready in IDLE.
    cyc(1, 32'h8000_003C, 0, 0, 0);
    cyc(0, 32'h0, 0, 1, 32'h4444_4444);
    cyc(1, 32'h8000_0004, 0, 0, 0);
    check("done_req_ignored", {31'b0, icache_hit | mem_req}, 32'h0);
    cyc(0, 32'h0, 0, 1, 32'hBAD0_BAD0);
    cyc(1, 32'h8000_0004, 0, 0, 0);
    check("idle_ready_no_write", icache_data, 32'h3333_3333);
    cyc(1, 32'h8000_003C, 0, 0, 0);
    check("last_index_hit", icache_data, 32'h4444_4444);

    // Reset in the middle of a refill.
    cyc(1, 32'h8000_0008, 0, 0, 0);
    idle();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    cyc(0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    idle();
    check("rst_refill_no_ready", {31'b0, icache_ready}, 32'h0);
    check("rst_refill_miss_cnt", miss_cnt, 32'd0);
    check("rst_refill_hit_cnt", hit_cnt, 32'd0);
    cyc(1, 32'h8000_0008, 0, 0, 0);
    check("rst_refill_miss", {31'b0, mem_req}, 32'h1);
    refill(32'h5555_5555);
    cyc(1, 32'h8000_0008, 0, 0, 0);
    check("after_rst_hit", icache_data, 32'h5555_5555);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
